// File: rtl/uu_acmac_ba_pkg.sv
// uu_acmac_ba_pkg: BA scoreboard layout, FSM encoding and status codes shared by the BA stages.
package uu_acmac_ba_pkg;
    localparam int BA_BMP_ENTRIES = 64;
    localparam logic [5:0] BA_BASIC_BITMAP_BUF_MASK = 6'h3F;
    localparam int BA_BMP_WORD_OFS = 1;
    localparam int BA_BUFWS_OFS = 66;
    localparam int BA_WINSTART_OFS = 67;
    localparam int BA_WINSIZE_OFS = 68;
    localparam int BA_HDR_WORDS = 3;

    localparam logic [31:0] UU_SUCCESS = 32'd0;
    localparam logic [31:0] UU_FAILURE = 32'd1;
    localparam logic [31:0] UU_BA_SESSION_INVALID = 32'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_HDR,
        ST_RD_BMP,
        ST_DRAIN,
        ST_DONE
    } ba_gen_state_e;

    function automatic logic ba_winsize_ok(input logic [15:0] winsize, input int entries);
        return winsize != 16'd0 && winsize <= 16'(entries);
    endfunction
endpackage

// File: rtl/uu_acmac_ba_bitmap_rotate.sv
// uu_acmac_ba_bitmap_rotate: rotates the raw scoreboard to the window start and masks it to winsize.
module uu_acmac_ba_bitmap_rotate
    import uu_acmac_ba_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0]         raw,
    input  logic [$clog2(N)-1:0] start,
    input  logic [15:0]          winsize,
    output logic [N-1:0]         bitmap
);
    logic [N-1:0] rot;
    logic [N-1:0] mask;

    always_comb begin
        rot = N'({raw, raw} >> start);
        mask = !ba_winsize_ok(winsize, N) ? '0 :
               winsize == 16'(N) ? '1 : (N'(1) << winsize) - N'(1);
        bitmap = rot & mask;
    end
endmodule

// File: rtl/uu_acmac_rx_ba_bitmap_gen.sv
// uu_acmac_rx_ba_bitmap_gen: reads one BA session scoreboard and builds SSC plus compressed BA bitmap.
module uu_acmac_rx_ba_bitmap_gen #(
    parameter int BA_BMP_ENTRIES = uu_acmac_ba_pkg::BA_BMP_ENTRIES,
    parameter int BA_BMP_WORD_OFS = uu_acmac_ba_pkg::BA_BMP_WORD_OFS,
    parameter int BA_BUFWS_OFS = uu_acmac_ba_pkg::BA_BUFWS_OFS,
    parameter int BA_WINSTART_OFS = uu_acmac_ba_pkg::BA_WINSTART_OFS,
    parameter int BA_WINSIZE_OFS = uu_acmac_ba_pkg::BA_WINSIZE_OFS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ba_gen_en,
    input  logic                      ba_gen_in_req,
    input  logic [13:0]               ba_gen_in_sta_offset,
    output logic                      ba_gen_out_busy,
    output logic                      ba_gen_out_sta_ba_en,
    output logic [14:0]               ba_gen_out_sta_ba_addr,
    input  logic [31:0]               ba_gen_in_sta_ba_data,
    output logic [15:0]               ba_gen_out_ssc,
    output logic [BA_BMP_ENTRIES-1:0] ba_gen_out_bitmap,
    output logic                      ba_gen_out_valid,
    output logic [31:0]               ba_gen_out_res
);
    import uu_acmac_ba_pkg::*;

    localparam int NR = BA_HDR_WORDS + BA_BMP_ENTRIES / 2;
    localparam int CW = $clog2(NR + 1);
    localparam int SW = $clog2(BA_BMP_ENTRIES);

    ba_gen_state_e state, state_nx;
    logic [13:0] ofs;
    logic [CW-1:0] cnt, rd_idx;
    logic [SW-1:0] buf_ws;
    logic [11:0] winstart;
    logic [15:0] winsize;
    logic [BA_BMP_ENTRIES-1:0] raw, rot;
    logic [14:0] hdr_ofs, rd_addr;
    logic accept, issue, kill;
    logic unused_bits;

    assign unused_bits = ^ba_gen_in_sta_ba_data[15:1];
    assign kill = rst_n || !ba_gen_en;
    // A req landing on the valid cycle is dropped, even though the FSM is already idle.
    assign accept = ba_gen_en && ba_gen_in_req && state == ST_IDLE && !ba_gen_out_valid;
    assign issue = state == ST_RD_HDR || state == ST_RD_BMP;

    always_comb begin
        hdr_ofs = cnt == CW'(0) ? 15'(BA_BUFWS_OFS) :
                  cnt == CW'(1) ? 15'(BA_WINSTART_OFS) : 15'(BA_WINSIZE_OFS);
        rd_addr = {1'b0, ofs} + (cnt < CW'(BA_HDR_WORDS) ? hdr_ofs :
                  15'(BA_BMP_WORD_OFS) + 15'(cnt) - 15'(BA_HDR_WORDS));
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = accept ? ST_RD_HDR : ST_IDLE;
            ST_RD_HDR: state_nx = cnt == CW'(BA_HDR_WORDS - 1) ? ST_RD_BMP : ST_RD_HDR;
            ST_RD_BMP: state_nx = cnt == CW'(NR - 1) ? ST_DRAIN : ST_RD_BMP;
            ST_DRAIN:  state_nx = ST_DONE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        state <= kill ? ST_IDLE : state_nx;
    end

    uu_acmac_ba_bitmap_rotate #(.N(BA_BMP_ENTRIES)) u_rotate (
        .raw(raw),
        .start(buf_ws),
        .winsize(winsize),
        .bitmap(rot)
    );

    always_ff @(posedge clk) begin
        if (kill) begin
            ofs <= '0;
            cnt <= '0;
            rd_idx <= '0;
            buf_ws <= '0;
            winstart <= '0;
            winsize <= '0;
            raw <= '0;
            ba_gen_out_busy <= 1'b0;
            ba_gen_out_sta_ba_en <= 1'b0;
            ba_gen_out_sta_ba_addr <= '0;
            ba_gen_out_ssc <= '0;
            ba_gen_out_bitmap <= '0;
            ba_gen_out_valid <= 1'b0;
            ba_gen_out_res <= UU_FAILURE;
        end else begin
            ba_gen_out_sta_ba_en <= issue;
            ba_gen_out_busy <= state != ST_IDLE && state != ST_DONE;
            ba_gen_out_valid <= state == ST_DONE;
            if (accept) begin
                ofs <= ba_gen_in_sta_offset;
                cnt <= '0;
            end else if (issue) begin
                cnt <= cnt + CW'(1);
            end
            if (issue) begin
                ba_gen_out_sta_ba_addr <= rd_addr;
                rd_idx <= cnt;
            end
            // Data returned this cycle belongs to the address issued one cycle earlier.
            if (ba_gen_out_sta_ba_en) begin
                if (rd_idx == CW'(0))
                    buf_ws <= ba_gen_in_sta_ba_data[16 +: SW] & BA_BASIC_BITMAP_BUF_MASK[SW-1:0];
                else if (rd_idx == CW'(1))
                    winstart <= ba_gen_in_sta_ba_data[27:16];
                else if (rd_idx == CW'(2))
                    winsize <= ba_gen_in_sta_ba_data[31:16];
                else
                    raw[2 * (int'(rd_idx) - BA_HDR_WORDS) +: 2] <=
                        {ba_gen_in_sta_ba_data[0], ba_gen_in_sta_ba_data[16]};
            end
            if (state == ST_DONE) begin
                ba_gen_out_ssc <= {winstart, 4'h0};
                ba_gen_out_bitmap <= rot;
                ba_gen_out_res <= ba_winsize_ok(winsize, BA_BMP_ENTRIES) ? UU_SUCCESS : UU_BA_SESSION_INVALID;
            end
        end
    end
endmodule

// File: tb/tb_uu_acmac_rx_ba_bitmap_gen.sv
// tb_uu_acmac_rx_ba_bitmap_gen: directed BA sessions checked cycle by cycle against a scoreboard-level model.
module tb_uu_acmac_rx_ba_bitmap_gen;
    import uu_acmac_ba_pkg::*;

    logic clk = 1'b0;
    logic rst_n, en, req;
    logic [13:0] offset;
    logic busy, mem_en, valid;
    logic [14:0] addr;
    logic [31:0] data, res;
    logic [15:0] ssc;
    logic [63:0] bitmap;
    logic [31:0] mem [0:32767];
    int n_chk = 0;
    int n_fail = 0;
    bit go = 1'b0;

    always #5 clk = ~clk;
    assign data = mem[addr];

    uu_acmac_rx_ba_bitmap_gen dut (
        .clk(clk),
        .rst_n(rst_n),
        .ba_gen_en(en),
        .ba_gen_in_req(req),
        .ba_gen_in_sta_offset(offset),
        .ba_gen_out_busy(busy),
        .ba_gen_out_sta_ba_en(mem_en),
        .ba_gen_out_sta_ba_addr(addr),
        .ba_gen_in_sta_ba_data(data),
        .ba_gen_out_ssc(ssc),
        .ba_gen_out_bitmap(bitmap),
        .ba_gen_out_valid(valid),
        .ba_gen_out_res(res)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected outputs derived straight from the session words in memory.
    int t = -1;
    int mo;
    logic e_busy = 0, e_en = 0, e_valid = 0;
    logic [14:0] e_addr = '0;
    logic [15:0] e_ssc = '0;
    logic [63:0] e_bmp = '0;
    logic [31:0] e_res = UU_FAILURE;

    function automatic logic [63:0] model_bitmap(input int o);
        logic [63:0] r, bm;
        int ws = int'(mem[o + 68][31:16]);
        int bws = int'(mem[o + 66][25:16]) % 64;
        bm = '0;
        for (int k = 0; k < 64; k++) r[k] = mem[o + 1 + k / 2][(k % 2 == 0) ? 16 : 0];
        if (ws == 0 || ws > 64) return '0;
        for (int i = 0; i < 64; i++) if (i < ws) bm[i] = r[(bws + i) % 64];
        return bm;
    endfunction

    always @(posedge clk) begin
        if (rst_n || !en) begin
            t = -1;
            e_busy = 0; e_en = 0; e_valid = 0;
            e_ssc = '0; e_bmp = '0; e_res = UU_FAILURE;
        end else begin
            if (t >= 0) t++;
            else if (req && !e_valid) begin
                t = 0;
                mo = int'(offset);
            end
            e_busy = t >= 1 && t <= 36;
            e_en = t >= 1 && t <= 35;
            e_addr = (t <= 3) ? 15'(mo + 65 + t) : 15'(mo + t - 3);
            e_valid = t == 37;
            if (t == 37) begin
                e_ssc = {mem[mo + 67][27:16], 4'h0};
                e_bmp = model_bitmap(mo);
                e_res = (mem[mo + 68][31:16] == 0 || mem[mo + 68][31:16] > 64) ?
                        UU_BA_SESSION_INVALID : UU_SUCCESS;
                t = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("busy", busy, e_busy);
            chk("mem_en", mem_en, e_en);
            chk("valid", valid, e_valid);
            chk("ssc", ssc, e_ssc);
            chk("bitmap", bitmap, e_bmp);
            chk("res", res, e_res);
            if (e_en) chk("addr", addr, e_addr);
        end
    end

    task automatic setup(input int o, input logic [9:0] bws, input logic [15:0] wst,
                         input logic [15:0] ws, input logic [63:0] ent);
        mem[o + 66] = {6'($urandom), bws, 16'($urandom)};
        mem[o + 67] = {wst, 16'($urandom)};
        mem[o + 68] = {ws, 16'($urandom)};
        for (int k = 0; k < 32; k++)
            mem[o + 1 + k] = {15'($urandom), ent[2 * k], 15'($urandom), ent[2 * k + 1]};
    endtask

    // kind: 0 normal, 1 en drop at cycle 20, 2 reset at cycle 20, 3 extra reqs while busy/valid
    task automatic txn(input int o, input int kind, input logic [63:0] x_bmp,
                       input logic [31:0] x_res, input logic [15:0] x_ssc);
        int n = 0;
        bit got = 0;
        @(negedge clk);
        req = 1;
        offset = 14'(o);
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            req = 0;
            if (kind == 3 && n == 10) req = 1;
            if (kind == 1) en = (n != 20);
            if (kind == 2) rst_n = (n == 20);
            if (valid) got = 1;
        end
        if (kind == 1 || kind == 2) begin
            chk("abort_no_valid", 64'(got), 64'd0);
            return;
        end
        chk("valid_seen", 64'(got), 64'd1);
        chk("latency", 64'(n - 1), 64'd37);
        chk("lit_bitmap", bitmap, x_bmp);
        chk("lit_model_bitmap", e_bmp, x_bmp);
        chk("lit_res", res, x_res);
        chk("lit_ssc", ssc, x_ssc);
        if (kind == 3) begin
            req = 1;
            @(negedge clk);
            req = 0;
            repeat (45) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        rst_n = 1; en = 0; req = 0; offset = '0;
        repeat (2) @(negedge clk);
        go = 1;
        chk("reset_res", res, UU_FAILURE);
        chk("reset_bitmap", bitmap, 64'd0);
        rst_n = 0; en = 1;
        repeat (2) @(negedge clk);

        setup(100, 10'd0, 16'h0100, 16'd64, 64'h8000_0000_0000_0003);
        setup(300, 10'h3FE, 16'h1005, 16'd64, 64'hC000_0000_0000_0001);
        setup(16380, 10'd5, 16'h0ABC, 16'd8, '1);
        setup(700, 10'd3, 16'h0123, 16'd0, '1);
        setup(800, 10'd9, 16'h0456, 16'd65, '1);

        txn(100, 0, 64'h8000_0000_0000_0003, UU_SUCCESS, 16'h1000);
        txn(300, 0, 64'h0000_0000_0000_0007, UU_SUCCESS, 16'h0050);
        txn(16380, 0, 64'h0000_0000_0000_00FF, UU_SUCCESS, 16'hABC0);
        txn(700, 0, 64'd0, UU_BA_SESSION_INVALID, 16'h1230);
        txn(800, 0, 64'd0, UU_BA_SESSION_INVALID, 16'h4560);
        txn(100, 1, 64'd0, UU_FAILURE, 16'h0);
        txn(100, 0, 64'h8000_0000_0000_0003, UU_SUCCESS, 16'h1000);
        txn(300, 2, 64'd0, UU_FAILURE, 16'h0);
        txn(300, 0, 64'h0000_0000_0000_0007, UU_SUCCESS, 16'h0050);
        txn(16380, 3, 64'h0000_0000_0000_00FF, UU_SUCCESS, 16'hABC0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
